// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the hazard/forwarding controller: scoreboard entry layout,
// the architectural zero register and the forwarding-select width helper.
package pipe_pkg;

  // Scoreboard rd field is sized for the widest register address in use;
  // narrower address widths are zero-extended into it.
  localparam int RD_W = 8;
  localparam int XZR  = 31;

  typedef struct packed {
    logic            valid;
    logic [RD_W-1:0] rd;
    logic            regwrite;
    logic            memread;
  } sb_entry_t;

  function automatic int sel_w(input int stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_match.sv
// Per-read-port forwarding resolver: picks the youngest live producer of rs
// and flags a load sitting in EX that this port depends on.
module fwd_match
  import pipe_pkg::*;
#(
  parameter int STAGES     = 3,
  parameter int REG_ADDR_W = 5,
  parameter int ZERO_REG   = XZR,
  parameter int SEL_W      = 2
) (
  input  sb_entry_t [STAGES-1:0] entries,
  input  logic [REG_ADDR_W-1:0]  rs,
  input  logic                   used,
  output logic [SEL_W-1:0]       sel,
  output logic                   load_hit
);

  logic [STAGES-1:0] hit;
  logic              found;
  logic              unused_memread;

  always_comb begin
    for (int unsigned k = 0; k < STAGES; k++) begin
      hit[k] = entries[k].valid && entries[k].regwrite &&
               (entries[k].rd != RD_W'(ZERO_REG)) &&
               used && (entries[k].rd == RD_W'(rs));
    end
  end

  // Ascending scan with a found flag so the youngest (lowest index) entry wins.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      if (!found && hit[k]) begin
        sel   = SEL_W'(k + 1);
        found = 1'b1;
      end
    end
  end

  assign load_hit = hit[0] && entries[0].memread;

  always_comb begin
    unused_memread = 1'b0;
    for (int unsigned k = 1; k < STAGES; k++) begin
      unused_memread = unused_memread ^ entries[k].memread;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller: STAGES-deep scoreboard of in-flight destinations,
// per-port forwarding selects, load-use stall and a saturating stall counter.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int STAGES     = 3,
  parameter int REG_ADDR_W = 5,
  parameter int READ_PORTS = 2,
  parameter int ZERO_REG   = XZR,
  parameter int CNT_W      = 32
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               id_valid,
  input  logic [READ_PORTS*REG_ADDR_W-1:0]   id_rs,
  input  logic [READ_PORTS-1:0]              id_rs_used,
  input  logic [REG_ADDR_W-1:0]              id_rd,
  input  logic                               id_regwrite,
  input  logic                               id_memread,
  input  logic                               flush,
  output logic [READ_PORTS*sel_w(STAGES)-1:0] fwd_sel,
  output logic                               stall,
  output logic [CNT_W-1:0]                   stall_count
);

  localparam int SEL_W = sel_w(STAGES);

  sb_entry_t [STAGES-1:0] sb;
  logic [READ_PORTS-1:0]  load_hit;
  logic                   accept;

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
    fwd_match #(
      .STAGES     (STAGES),
      .REG_ADDR_W (REG_ADDR_W),
      .ZERO_REG   (ZERO_REG),
      .SEL_W      (SEL_W)
    ) u_match (
      .entries  (sb),
      .rs       (id_rs[p*REG_ADDR_W +: REG_ADDR_W]),
      .used     (id_rs_used[p]),
      .sel      (fwd_sel[p*SEL_W +: SEL_W]),
      .load_hit (load_hit[p])
    );
  end

  assign stall  = id_valid && !flush && (|load_hit);
  assign accept = id_valid && !stall && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      sb <= '0;
    end else begin
      sb[0] <= '{valid:    accept,
                 rd:       RD_W'(id_rd),
                 regwrite: id_regwrite,
                 memread:  id_memread};
      for (int unsigned k = 1; k < STAGES; k++) begin
        sb[k] <= sb[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
    end else if (stall && (stall_count != '1)) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed hazard scenarios then random
// traffic, all compared against a timestamp-based model of in-flight producers.
module tb_pipe_hazard_ctrl;

  localparam int STAGES = 3;
  localparam int RAW    = 5;
  localparam int RP     = 2;
  localparam int ZR     = 31;
  localparam int CW     = 4;
  localparam int SW     = 2;
  localparam int CMAX   = 15;

  logic              clk = 1'b0;
  logic              reset;
  logic              id_valid;
  logic [RP*RAW-1:0] id_rs;
  logic [RP-1:0]     id_rs_used;
  logic [RAW-1:0]    id_rd;
  logic              id_regwrite;
  logic              id_memread;
  logic              flush;
  logic [RP*SW-1:0]  fwd_sel;
  logic              stall;
  logic [CW-1:0]     stall_count;

  pipe_hazard_ctrl #(
    .STAGES     (STAGES),
    .REG_ADDR_W (RAW),
    .READ_PORTS (RP),
    .ZERO_REG   (ZR),
    .CNT_W      (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rs_used  (id_rs_used),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread),
    .flush       (flush),
    .fwd_sel     (fwd_sel),
    .stall       (stall),
    .stall_count (stall_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model: each accepted producer remembers the edge number it entered EX on;
  // its distance from EX is simply (current edge count - that edge number).
  typedef struct {
    int t;
    int rd;
    bit rw;
    bit mr;
  } prod_t;

  prod_t prods[$];
  int    edge_n = 0;
  int    m_count = 0;

  task automatic step(input bit rst, input bit v, input int rs0, input int rs1,
                      input bit [1:0] used, input int rd, input bit rw,
                      input bit mr, input bit fl, input bit do_check);
    int  rs [RP];
    int  exp_sel [RP];
    bit  any_load;
    bit  exp_stall;
    int  best;
    int  age;
    @(negedge clk);
    reset       = rst;
    id_valid    = v;
    id_rs       = {RAW'(rs1), RAW'(rs0)};
    id_rs_used  = used;
    id_rd       = RAW'(rd);
    id_regwrite = rw;
    id_memread  = mr;
    flush       = fl;
    #1;
    rs[0] = rs0;
    rs[1] = rs1;
    any_load = 1'b0;
    for (int p = 0; p < RP; p++) begin
      best = -1;
      foreach (prods[i]) begin
        age = edge_n - prods[i].t;
        if (age < STAGES && prods[i].rw && prods[i].rd != ZR && used[p] &&
            prods[i].rd == rs[p]) begin
          if (best < 0 || age < best) best = age;
          if (age == 0 && prods[i].mr) any_load = 1'b1;
        end
      end
      exp_sel[p] = best + 1;
    end
    exp_stall = v && !fl && any_load;
    if (do_check) begin
      check("stall", int'(stall), int'(exp_stall));
      check("fwd_sel0", int'(fwd_sel[SW-1:0]), exp_sel[0]);
      check("fwd_sel1", int'(fwd_sel[2*SW-1:SW]), exp_sel[1]);
      check("stall_count", int'(stall_count), m_count);
    end
    // Advance the model across the coming clock edge.
    edge_n++;
    if (rst) begin
      prods.delete();
      m_count = 0;
    end else begin
      if (v && !exp_stall && !fl) prods.push_back('{t: edge_n, rd: rd, rw: rw, mr: mr});
      while (prods.size() > 0 && edge_n - prods[0].t >= STAGES) void'(prods.pop_front());
      if (exp_stall && m_count < CMAX) m_count++;
    end
  endtask

  task automatic nop();
    step(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1);
  endtask

  task automatic instr(input int rs0, input int rs1, input bit [1:0] used,
                       input int rd, input bit rw, input bit mr, input bit fl);
    step(0, 1, rs0, rs1, used, rd, rw, mr, fl, 1);
  endtask

  function automatic int pick_reg();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 4) return r;
    if (r < 6) return ZR;
    return int'($urandom_range(0, 31));
  endfunction

  initial begin
    // 1: reset then idle
    step(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    repeat (5) nop();

    // 2: ADD X1 then consumer at distance 1, 2, 3, 4
    for (int gap = 0; gap < 4; gap++) begin
      instr(0, 0, 2'b00, 1, 1, 0, 0);
      for (int g = 0; g < gap; g++) nop();
      instr(1, 0, 2'b01, 5, 1, 0, 0);
      repeat (3) nop();
    end

    // 3: LDUR X2 then ADD rs1=X2, held while stalled
    instr(0, 0, 2'b00, 2, 1, 1, 0);
    instr(0, 2, 2'b10, 6, 1, 0, 0);
    instr(0, 2, 2'b10, 6, 1, 0, 0);
    repeat (3) nop();

    // 4: two writers of X3, consumer on both ports
    instr(0, 0, 2'b00, 3, 1, 0, 0);
    instr(0, 0, 2'b00, 3, 1, 0, 0);
    instr(3, 3, 2'b11, 7, 1, 0, 0);
    repeat (3) nop();

    // 5: X31 as destination, including a load
    instr(0, 0, 2'b00, ZR, 1, 0, 0);
    instr(ZR, ZR, 2'b11, 8, 1, 0, 0);
    instr(0, 0, 2'b00, ZR, 1, 1, 0);
    instr(ZR, ZR, 2'b11, 8, 1, 0, 0);
    repeat (3) nop();

    // 6: load-use coinciding with flush, then counter saturation, then mid-run reset
    instr(0, 0, 2'b00, 4, 1, 1, 0);
    instr(4, 0, 2'b01, 9, 1, 0, 1);
    nop();
    for (int i = 0; i < 20; i++) begin
      instr(0, 0, 2'b00, 2, 1, 1, 0);
      instr(2, 2, 2'b11, 10, 1, 0, 0);
      instr(2, 2, 2'b11, 10, 1, 0, 0);
    end
    instr(0, 0, 2'b00, 1, 1, 0, 0);
    instr(0, 0, 2'b00, 2, 1, 0, 0);
    step(1, 1, 1, 2, 2'b11, 3, 1, 0, 0, 1);
    instr(1, 2, 2'b11, 3, 1, 0, 0);
    nop();

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 99) < 1,
           $urandom_range(0, 9) < 8,
           pick_reg(), pick_reg(),
           2'($urandom_range(0, 3)),
           pick_reg(),
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 9) == 0,
           1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
